// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: FSM state encoding, mode
// constants and a constant-width helper.
package scan_decoder_pkg;

    // FSM state encoding.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDirect = 2'd1,
        StScan   = 2'd2
    } state_e;

    // Values of the mode input.
    localparam logic ModeDirect = 1'b0;
    localparam logic ModeScan   = 1'b1;

    // Smallest r with 2**r >= v; used to size counters at elaboration time.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// Dwell counter for the scan decoder: counts enabled scan cycles and
// flags the cycle on which the current output has been held long enough.
module scan_decoder_dwell_counter
    import scan_decoder_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    // Wide enough to hold the value DWELL itself.
    localparam int unsigned CntW = (clog2(DWELL + 1) < 1) ? 1 : clog2(DWELL + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_end;

    assign at_end = (cnt_q == CntW'(DWELL - 1));
    assign tc_o   = inc_i && at_end;

    // Next count: clear on scan entry, otherwise step and roll over at DWELL-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = at_end ? '0 : cnt_q + CntW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with output enable, load/ready
// handshake and an auto-scan mode for multiplexed display strobes.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  load_i,
    output logic                  ready_o,
    output logic [(1<<SEL_W)-1:0] out_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic                  wrap_o
);

    localparam int unsigned NOut = 1 << SEL_W;

    state_e            state_q;
    logic [SEL_W-1:0]  idx_q;
    logic [NOut-1:0]   out_q;
    logic              wrap_q;

    logic              ready;
    logic              cnt_clr, cnt_inc, cnt_tc;
    logic [SEL_W-1:0]  idx_next;

    function automatic logic [NOut-1:0] onehot(input logic [SEL_W-1:0] i);
        return NOut'(1) << i;
    endfunction

    // A load is only accepted while enabled and in direct mode; it is never queued.
    assign ready    = en_i && (mode_i == ModeDirect);
    assign idx_next = idx_q + SEL_W'(1);

    // The counter clears on the scan entry edge and counts every enabled scan cycle.
    assign cnt_clr = en_i && (mode_i == ModeScan) && (state_q != StScan);
    assign cnt_inc = en_i && (mode_i == ModeScan) && (state_q == StScan);

    scan_decoder_dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(cnt_clr),
        .inc_i(cnt_inc),
        .tc_o (cnt_tc)
    );

    // FSM, held index, registered one-hot output and wrap pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (!en_i) begin
            // Blank the outputs but keep state, index and count frozen.
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                StIdle, StDirect: begin
                    if (mode_i == ModeScan) begin
                        state_q <= StScan;
                        out_q   <= onehot(idx_q);
                    end else if (load_i && ready) begin
                        state_q <= StDirect;
                        idx_q   <= sel_i;
                        out_q   <= onehot(sel_i);
                    end else if (state_q == StDirect) begin
                        out_q <= onehot(idx_q);
                    end else begin
                        out_q <= '0;
                    end
                end
                StScan: begin
                    if (mode_i == ModeDirect) begin
                        // Leaving scan keeps the index; a load this cycle is accepted.
                        state_q <= StDirect;
                        if (load_i && ready) begin
                            idx_q <= sel_i;
                            out_q <= onehot(sel_i);
                        end else begin
                            out_q <= onehot(idx_q);
                        end
                    end else if (cnt_tc) begin
                        idx_q  <= idx_next;
                        out_q  <= onehot(idx_next);
                        wrap_q <= &idx_q;
                    end else begin
                        out_q <= onehot(idx_q);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    out_q   <= '0;
                end
            endcase
        end
    end

    assign ready_o = ready;
    assign out_o   = out_q;
    assign idx_o   = idx_q;
    assign wrap_o  = wrap_q;

    // The output is never multi-hot.
    out_onehot_a: assert property (@(posedge clk_i) $onehot0(out_q));

endmodule
